// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared register map and bit positions for the timer block
package timer_pkg;

    // Word addresses, compared against the full 24-bit bus address
    localparam logic [23:0] TIMER_ADR_CTRL     = 24'd0;
    localparam logic [23:0] TIMER_ADR_STATUS   = 24'd1;
    localparam logic [23:0] TIMER_ADR_RELOAD   = 24'd2;
    localparam logic [23:0] TIMER_ADR_COUNT    = 24'd3;
    localparam logic [23:0] TIMER_ADR_PRESCALE = 24'd4;
    localparam logic [23:0] TIMER_ADR_CAPTURE  = 24'd5;

    // CTRL bit positions
    localparam int TIMER_CTRL_EN      = 0;
    localparam int TIMER_CTRL_ONESHOT = 1;
    localparam int TIMER_CTRL_IE      = 2;

    // STATUS bit positions
    localparam int TIMER_STATUS_MATCH = 0;
    localparam int TIMER_STATUS_CAPT  = 1;

endpackage

// File: rtl/timer_if.sv
// rtl/timer_if.sv - Wishbone register bus bundle for the timer
// Signals: wb_cyc/wb_stb/wb_we strobes, wb_adr word address, wb_i_dat write
// data, wb_ack zero-wait acknowledge, wb_o_dat read data.
interface timer_if;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [23:0] wb_adr;
    logic [15:0] wb_i_dat;
    logic        wb_ack;
    logic [15:0] wb_o_dat;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_i_dat,
        input  wb_ack, wb_o_dat
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_i_dat,
        output wb_ack, wb_o_dat
    );
endinterface

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - divide-by-(PRESCALE+1) tick generator
// Ports: i_clk, i_rst_n (sync, active-low), i_en (run), i_prescale (terminal
// value), i_clr (restart count), o_tick (one-cycle tick, combinational).
module timer_prescaler (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic [15:0] i_prescale,
    input  logic        i_clr,
    output logic        o_tick
);

    logic [15:0] pre_cnt_q;
    logic [15:0] pre_cnt_d;

    always_comb begin
        o_tick    = i_en && (pre_cnt_q == i_prescale);
        pre_cnt_d = pre_cnt_q + 16'd1;
        // Held at zero while stopped so the first tick after enabling
        // lands exactly PRESCALE+1 edges later.
        if (!i_en || i_clr || o_tick) begin
            pre_cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

endmodule

// File: rtl/timer.sv
// rtl/timer.sv - programmable down-counting timer with Wishbone registers
// Ports: i_clk, i_rst_n (sync, active-low), i_capture (external event),
// o_irq (level interrupt), wb (timer_if.slave register bus).
// Optional feature macro: TIMER_CAPTURE_EN (capture register + CAPT flag).
module timer
    import timer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_capture,
    output logic   o_irq,
    timer_if.slave wb
);

    logic [2:0]       ctrl_q, ctrl_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] reload_q, reload_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      prescale_q, prescale_d;

    logic wr_en, wr_ctrl, wr_status, wr_reload, wr_count, wr_prescale;
    logic tick, match_evt;

    assign wb.wb_ack   = wb.wb_cyc & wb.wb_stb;
    assign wr_en       = wb.wb_cyc & wb.wb_stb & wb.wb_we;
    assign wr_ctrl     = wr_en && (wb.wb_adr == TIMER_ADR_CTRL);
    assign wr_status   = wr_en && (wb.wb_adr == TIMER_ADR_STATUS);
    assign wr_reload   = wr_en && (wb.wb_adr == TIMER_ADR_RELOAD);
    assign wr_count    = wr_en && (wb.wb_adr == TIMER_ADR_COUNT);
    assign wr_prescale = wr_en && (wb.wb_adr == TIMER_ADR_PRESCALE);

    timer_prescaler u_prescaler (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_en       (ctrl_q[TIMER_CTRL_EN]),
        .i_prescale (prescale_q),
        .i_clr      (wr_count),
        .o_tick     (tick)
    );

    // A COUNT write in the same cycle swallows the tick entirely.
    assign match_evt = tick && !wr_count && (count_q == '0);

`ifdef TIMER_CAPTURE_EN
    // [0],[1]: synchronizer stages; [2]: previous synced value for edge detect
    logic [2:0]       capt_sync_q, capt_sync_d;
    logic             capt_q, capt_d;
    logic [CNT_W-1:0] capture_q, capture_d;
    logic             capt_evt;

    always_comb begin
        capt_sync_d = {capt_sync_q[1:0], i_capture};
        capt_evt    = capt_sync_q[1] & ~capt_sync_q[2];
        // Set has priority over a software clear in the same cycle.
        capt_d      = (capt_q & ~(wr_status & wb.wb_i_dat[TIMER_STATUS_CAPT])) | capt_evt;
        capture_d   = capt_evt ? count_q : capture_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            capt_sync_q <= '0;
            capt_q      <= 1'b0;
            capture_q   <= '0;
        end else begin
            capt_sync_q <= capt_sync_d;
            capt_q      <= capt_d;
            capture_q   <= capture_d;
        end
    end
`else
    logic             capt_q;
    logic [CNT_W-1:0] capture_q;
    logic             unused_capture;

    assign capt_q         = 1'b0;
    assign capture_q      = '0;
    assign unused_capture = i_capture;
`endif

    always_comb begin
        ctrl_d     = ctrl_q;
        reload_d   = reload_q;
        count_d    = count_q;
        prescale_d = prescale_q;

        if (tick) begin
            count_d = (count_q == '0) ? reload_q : count_q - CNT_W'(1);
        end
        if (match_evt && ctrl_q[TIMER_CTRL_ONESHOT]) begin
            ctrl_d[TIMER_CTRL_EN] = 1'b0;
        end

        // Bus writes come last so they override the counter's own updates.
        if (wr_ctrl)     ctrl_d     = wb.wb_i_dat[2:0];
        if (wr_reload)   reload_d   = wb.wb_i_dat[CNT_W-1:0];
        if (wr_count)    count_d    = wb.wb_i_dat[CNT_W-1:0];
        if (wr_prescale) prescale_d = wb.wb_i_dat;

        match_d = (match_q & ~(wr_status & wb.wb_i_dat[TIMER_STATUS_MATCH])) | match_evt;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ctrl_q     <= '0;
            match_q    <= 1'b0;
            reload_q   <= '0;
            count_q    <= '0;
            prescale_q <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            match_q    <= match_d;
            reload_q   <= reload_d;
            count_q    <= count_d;
            prescale_q <= prescale_d;
        end
    end

    logic [15:0] reload_ext, count_ext, capture_ext, rdata;

    always_comb begin
        reload_ext               = '0;
        count_ext                = '0;
        capture_ext              = '0;
        reload_ext[CNT_W-1:0]    = reload_q;
        count_ext[CNT_W-1:0]     = count_q;
        capture_ext[CNT_W-1:0]   = capture_q;

        case (wb.wb_adr)
            TIMER_ADR_CTRL:     rdata = {13'd0, ctrl_q};
            TIMER_ADR_STATUS:   rdata = {14'd0, capt_q, match_q};
            TIMER_ADR_RELOAD:   rdata = reload_ext;
            TIMER_ADR_COUNT:    rdata = count_ext;
            TIMER_ADR_PRESCALE: rdata = prescale_q;
            TIMER_ADR_CAPTURE:  rdata = capture_ext;
            default:            rdata = '0;
        endcase
        wb.wb_o_dat = rdata;
    end

    assign o_irq = ctrl_q[TIMER_CTRL_IE] & (match_q | capt_q);

endmodule

// File: tb/tb_timer.sv
// tb/tb_timer.sv - self-checking bench for the timer peripheral
module tb_timer;
    import timer_pkg::*;

    localparam int CNT_W = 16;
    localparam int MOD   = 1 << CNT_W;
`ifdef TIMER_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    logic i_capture = 1'b0;
    logic o_irq;

    timer_if bus ();

    timer #(.CNT_W(CNT_W)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_capture (i_capture),
        .o_irq     (o_irq),
        .wb        (bus.slave)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // One bus cycle: inputs applied mid-cycle, results sampled 1ns later,
    // the write (if any) takes effect on the following rising edge.
    task automatic bus_op(input logic we, input logic [23:0] adr, input logic [15:0] dat,
                          output logic [15:0] rd);
        @(negedge i_clk);
        bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = we;
        bus.wb_adr = adr;  bus.wb_i_dat = dat;
        #1;
        rd = bus.wb_o_dat;
        check("ack", int'(bus.wb_ack), 1);
        @(posedge i_clk);
        #1;
        bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
    endtask

    task automatic wr(input logic [23:0] adr, input logic [15:0] dat);
        logic [15:0] d;
        bus_op(1'b1, adr, dat, d);
    endtask

    task automatic rd_chk(input string name, input logic [23:0] adr, input int exp);
        logic [15:0] d;
        bus_op(1'b0, adr, 16'd0, d);
        check(name, int'(d), exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // ---------------- reference model (state after the last edge) ----------------
    int m_ctrl, m_match, m_capt, m_reload, m_count, m_ps, m_pre, m_capture;
    int m_hist[3];   // i_capture as seen 1, 2 and 3 edges ago

    function automatic int m_read(input logic [23:0] a);
        case (a)
            24'd0:   return m_ctrl;
            24'd1:   return m_match | (m_capt << 1);
            24'd2:   return m_reload;
            24'd3:   return m_count;
            24'd4:   return m_ps;
            24'd5:   return m_capture;
            default: return 0;
        endcase
    endfunction

    function automatic int m_irq();
        return ((m_ctrl >> 2) & 1) & ((m_match | m_capt) != 0 ? 1 : 0);
    endfunction

    task automatic model_edge(input logic rst_n, input logic cyc, input logic we,
                              input logic [23:0] adr, input logic [15:0] dat, input logic cap);
        bit wr_any, wr_cnt, en, tick, mev, cev;
        int old_count;
        if (!rst_n) begin
            m_ctrl = 0; m_match = 0; m_capt = 0; m_reload = 0; m_count = 0;
            m_ps = 0; m_pre = 0; m_capture = 0; m_hist = '{0, 0, 0};
            return;
        end
        wr_any    = cyc && we;
        wr_cnt    = wr_any && adr == 24'd3;
        en        = (m_ctrl & 1) != 0;
        tick      = en && (m_pre == m_ps);
        old_count = m_count;
        mev       = tick && !wr_cnt && (old_count == 0);
        cev       = CAP && m_hist[1] == 1 && m_hist[2] == 0;

        // Cycles counted since the last tick / enable / COUNT write
        m_pre = (!en || tick || wr_cnt) ? 0 : (m_pre + 1) % 65536;
        if (tick && !wr_cnt) m_count = (old_count == 0) ? m_reload : old_count - 1;
        if (mev && (m_ctrl & 2) != 0) m_ctrl = m_ctrl & 6;
        if (cev) m_capture = old_count;

        if (wr_any) begin
            case (adr)
                24'd0: m_ctrl   = dat & 7;
                24'd1: begin
                    if (dat[0]) m_match = 0;
                    if (dat[1]) m_capt  = 0;
                end
                24'd2: m_reload = dat % MOD;
                24'd3: m_count  = dat % MOD;
                24'd4: m_ps     = int'(dat);
                default: ;
            endcase
        end
        if (mev) m_match = 1;
        if (cev) m_capt  = 1;
        if (CAP) begin
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = int'(cap);
        end
    endtask

    // ---------------- register access vectors ----------------
    typedef struct {
        logic        we;
        logic [23:0] adr;
        logic [15:0] dat;
        int          exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, summary not printed");
        $fatal(1);
    end

    initial begin
        logic        r_rst, r_cyc, r_we, r_cap;
        logic [23:0] r_adr;
        logic [15:0] r_dat;
        int          op;

        bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
        bus.wb_adr = '0;   bus.wb_i_dat = '0;

        // Reset held for two edges
        i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        check("reset_irq", int'(o_irq), 0);

        vecs.push_back('{1'b0, TIMER_ADR_CTRL,     16'h0000, 0,      "rst_ctrl"});
        vecs.push_back('{1'b0, TIMER_ADR_STATUS,   16'h0000, 0,      "rst_status"});
        vecs.push_back('{1'b0, TIMER_ADR_RELOAD,   16'h0000, 0,      "rst_reload"});
        vecs.push_back('{1'b0, TIMER_ADR_COUNT,    16'h0000, 0,      "rst_count"});
        vecs.push_back('{1'b0, TIMER_ADR_PRESCALE, 16'h0000, 0,      "rst_prescale"});
        vecs.push_back('{1'b0, TIMER_ADR_CAPTURE,  16'h0000, 0,      "rst_capture"});
        vecs.push_back('{1'b0, 24'd6,              16'h0000, 0,      "rst_adr6"});
        vecs.push_back('{1'b1, TIMER_ADR_RELOAD,   16'h1234, 0,      "w_reload"});
        vecs.push_back('{1'b0, TIMER_ADR_RELOAD,   16'h0000, 'h1234, "r_reload"});
        vecs.push_back('{1'b1, 24'h010002,         16'hBEEF, 0,      "w_alias"});
        vecs.push_back('{1'b0, TIMER_ADR_RELOAD,   16'h0000, 'h1234, "r_reload_noalias"});
        vecs.push_back('{1'b0, 24'h010002,         16'h0000, 0,      "r_alias"});
        vecs.push_back('{1'b1, TIMER_ADR_PRESCALE, 16'hA5A5, 0,      "w_prescale"});
        vecs.push_back('{1'b0, TIMER_ADR_PRESCALE, 16'h0000, 'hA5A5, "r_prescale"});
        vecs.push_back('{1'b1, TIMER_ADR_CTRL,     16'hFFFE, 0,      "w_ctrl"});
        vecs.push_back('{1'b0, TIMER_ADR_CTRL,     16'h0000, 'h6,    "r_ctrl_mask"});
        vecs.push_back('{1'b1, TIMER_ADR_COUNT,    16'h0055, 0,      "w_count"});
        vecs.push_back('{1'b0, TIMER_ADR_COUNT,    16'h0000, 'h55,   "r_count"});
        vecs.push_back('{1'b1, TIMER_ADR_STATUS,   16'hFFFF, 0,      "w_status"});
        vecs.push_back('{1'b0, TIMER_ADR_STATUS,   16'h0000, 0,      "r_status"});
        vecs.push_back('{1'b1, TIMER_ADR_CTRL,     16'h0000, 0,      "w_ctrl0"});
        vecs.push_back('{1'b0, TIMER_ADR_CTRL,     16'h0000, 0,      "r_ctrl0"});

        foreach (vecs[i]) begin
            if (vecs[i].we) wr(vecs[i].adr, vecs[i].dat);
            else            rd_chk(vecs[i].name, vecs[i].adr, vecs[i].exp);
        end

        // Auto-reload: period (3+1)*(1+1) = 8 edges
        wr(TIMER_ADR_PRESCALE, 16'd1);
        wr(TIMER_ADR_RELOAD,   16'd3);
        wr(TIMER_ADR_COUNT,    16'd3);
        wr(TIMER_ADR_CTRL,     16'h5);          // enable edge N
        idle(7);  check("ar_irq_before", int'(o_irq), 0);
        idle(1);  check("ar_irq_first",  int'(o_irq), 1);   // N+8
        rd_chk("ar_status", TIMER_ADR_STATUS, 1);            // edge N+9
        wr(TIMER_ADR_STATUS, 16'd1);                         // edge N+10
        check("ar_irq_cleared", int'(o_irq), 0);
        idle(5);  check("ar_irq_gap",    int'(o_irq), 0);   // N+15
        idle(1);  check("ar_irq_second", int'(o_irq), 1);   // N+16
        rd_chk("ar_count_reloaded", TIMER_ADR_COUNT, 3);
        wr(TIMER_ADR_CTRL, 16'h0);
        wr(TIMER_ADR_STATUS, 16'd1);

        // One-shot: match 3 ticks after enable, then stop
        wr(TIMER_ADR_PRESCALE, 16'd0);
        wr(TIMER_ADR_RELOAD,   16'd2);
        wr(TIMER_ADR_COUNT,    16'd2);
        wr(TIMER_ADR_CTRL,     16'h7);
        idle(2);  check("os_irq_before", int'(o_irq), 0);
        idle(1);  check("os_irq_match",  int'(o_irq), 1);
        rd_chk("os_ctrl", TIMER_ADR_CTRL, 6);
        rd_chk("os_count", TIMER_ADR_COUNT, 2);
        idle(10);
        rd_chk("os_count_held", TIMER_ADR_COUNT, 2);
        wr(TIMER_ADR_STATUS, 16'd1);
        idle(5);  check("os_no_rematch", int'(o_irq), 0);

        // CTRL write on the one-shot match edge keeps the written EN
        wr(TIMER_ADR_COUNT, 16'd2);
        wr(TIMER_ADR_CTRL,  16'h7);
        idle(2);
        wr(TIMER_ADR_CTRL,  16'h7);
        rd_chk("col_ctrl_en_wins", TIMER_ADR_CTRL, 7);
        wr(TIMER_ADR_CTRL, 16'h0);
        wr(TIMER_ADR_STATUS, 16'd1);

        // STATUS clear on the match edge: set wins
        wr(TIMER_ADR_COUNT, 16'd2);
        wr(TIMER_ADR_CTRL,  16'h5);
        idle(2);
        wr(TIMER_ADR_STATUS, 16'd1);
        check("col_clear_irq", int'(o_irq), 1);
        rd_chk("col_clear_status", TIMER_ADR_STATUS, 1);

        // COUNT write on a tick edge: written value, no decrement
        wr(TIMER_ADR_COUNT, 16'd5);
        rd_chk("col_count_write", TIMER_ADR_COUNT, 5);
        rd_chk("col_count_next",  TIMER_ADR_COUNT, 4);
        wr(TIMER_ADR_CTRL, 16'h0);
        wr(TIMER_ADR_STATUS, 16'd1);

        // Reset mid-operation together with a CTRL write
        wr(TIMER_ADR_PRESCALE, 16'd3);
        wr(TIMER_ADR_RELOAD,   16'h20);
        wr(TIMER_ADR_COUNT,    16'h10);
        wr(TIMER_ADR_CTRL,     16'h5);
        idle(3);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = 1'b1;
        bus.wb_adr = TIMER_ADR_CTRL; bus.wb_i_dat = 16'h7;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
        check("mr_irq", int'(o_irq), 0);
        for (int a = 0; a < 6; a++) rd_chk($sformatf("mr_reg%0d", a), 24'(a), 0);

        // Capture event while COUNT=7 is held
        wr(TIMER_ADR_COUNT, 16'd7);
        wr(TIMER_ADR_CTRL,  16'h4);
        @(negedge i_clk);
        i_capture = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        check("cap_latency_irq", int'(o_irq), 0);
        @(posedge i_clk);
        #1;
        check("cap_irq", int'(o_irq), CAP ? 1 : 0);
        i_capture = 1'b0;
        rd_chk("cap_value",  TIMER_ADR_CAPTURE, CAP ? 7 : 0);
        rd_chk("cap_status", TIMER_ADR_STATUS,  CAP ? 2 : 0);
        wr(TIMER_ADR_STATUS, 16'd2);
        check("cap_cleared_irq", int'(o_irq), 0);

        // Randomized traffic against the reference model
        r_cap = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            r_rst = (c == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
            op    = $urandom_range(0, 9);
            r_cyc = (op >= 4);
            r_we  = (op >= 7);
            r_adr = ($urandom_range(0, 15) == 0) ? 24'($urandom) : 24'($urandom_range(0, 6));
            r_dat = 16'($urandom);
            if ($urandom_range(0, 7) != 0) begin
                if (r_adr == TIMER_ADR_RELOAD || r_adr == TIMER_ADR_COUNT)
                    r_dat = 16'($urandom_range(0, 6));
                else if (r_adr == TIMER_ADR_PRESCALE)
                    r_dat = 16'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 7) == 0) r_cap = ~r_cap;

            @(negedge i_clk);
            i_rst_n = r_rst; i_capture = r_cap;
            bus.wb_cyc = r_cyc; bus.wb_stb = r_cyc; bus.wb_we = r_we;
            bus.wb_adr = r_adr; bus.wb_i_dat = r_dat;
            #1;
            check("rnd_ack", int'(bus.wb_ack), int'(r_cyc));
            check("rnd_irq", int'(o_irq), m_irq());
            if (r_cyc && !r_we)
                check($sformatf("rnd_read_adr%0h", r_adr), int'(bus.wb_o_dat), m_read(r_adr));
            @(posedge i_clk);
            model_edge(r_rst, r_cyc, r_we, r_adr, r_dat, r_cap);
        end

        #1;
        i_rst_n = 1'b1;
        bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/timer.md
# timer

- Programmable down-counting timer peripheral on the Wishbone bus.
- Generates a level interrupt that feeds one `i_irq` line of the interrupt controller, which edge-detects its rising edge.
- Provides a prescaler, auto-reload or one-shot mode, and a sticky match flag cleared by software.
- Optionally provides an external-event capture register.

## Interface
- `CNT_W`, default 16: counter/reload width, legal 1..16; narrower registers read zero-extended to 16 bits.
- `i_clk` in 1: clock; all logic on its rising edge.
- `i_rst_n` in 1: reset, synchronous, active-low.
- `o_irq` out 1: level interrupt, `= flag_match & ctrl_ie`; routed to an interrupt controller `i_irq` bit.
- `i_capture` in 1: external capture event; used only with `TIMER_CAPTURE_EN`, otherwise ignored.
- `wb_cyc`, `wb_stb`, `wb_we` in 1 each: Wishbone cycle, strobe and write.
- `wb_ack` out 1: `= wb_cyc & wb_stb`, combinational, zero wait states.
- `wb_adr` in 24: word address, full 24-bit compare.
- `wb_i_dat` in 16: write data.
- `wb_o_dat` out 16: read data, combinational from `wb_adr`.

## Operation
- Register map (write strobe = `wb_cyc & wb_stb & wb_we` and address match):
  - 0 CTRL: bit0 EN, bit1 ONESHOT, bit2 IE; other bits read 0.
  - 1 STATUS: bit0 MATCH, bit1 CAPT; write-1-to-clear.
  - 2 RELOAD.
  - 3 COUNT: read returns live value; a write loads the counter.
  - 4 PRESCALE: 16 bit.
  - 5 CAPTURE: read-only.
  - All other addresses read 0; writes to them are ignored.
- Prescaler: `pre_cnt` counts 0..PRESCALE. Tick when `pre_cnt == PRESCALE` and EN=1, then `pre_cnt` returns to 0. `pre_cnt` is held at 0 while EN=0. PRESCALE=0 gives a tick every cycle.
- Counter: on each tick, if COUNT≠0, decrement. If COUNT==0, this is a match event:
  - COUNT ← RELOAD and MATCH ← 1.
  - If ONESHOT=1, EN ← 0.
- Period is (RELOAD+1)·(PRESCALE+1) cycles. RELOAD=0 gives a match every tick, and MATCH stays high.
- A COUNT write also clears `pre_cnt`.
- Arithmetic is modulo 2^CNT_W. COUNT/RELOAD writes take `wb_i_dat[CNT_W-1:0]`.
- Simultaneous events:
  - MATCH clear write and a match event in the same cycle: set wins, MATCH=1.
  - COUNT write and a tick in the same cycle: the write wins, with no decrement and no match.
  - CTRL write and a one-shot match in the same cycle: the written EN wins.
- `o_irq` stays high until MATCH is cleared or IE is cleared.
- Re-asserting after a clear requires a new match. The downstream controller sees a new rising edge only after `o_irq` has been low for at least 1 cycle.
- Reset mid-count: next edge with `i_rst_n=0` zeroes all registers, `pre_cnt` and flags. Bus writes in that cycle are ignored.

## Timing
- Reset values: CTRL=0, STATUS=0, RELOAD=0, COUNT=0, PRESCALE=0, CAPTURE=0, `pre_cnt`=0, `o_irq`=0.
- `wb_ack` is always asserted whenever `wb_cyc & wb_stb`. `wb_o_dat` is valid in the same cycle.
- A register write is visible on a read starting the next cycle.
- Write of CTRL.EN=1 at edge N: first tick at edge N+1+PRESCALE.
- Match tick at edge M: MATCH=1 and `o_irq`=1 after edge M (registered, 1-cycle latency from the tick).
- STATUS clear at edge C: `o_irq` low after edge C.

## Configuration
- `TIMER_CAPTURE_EN` defined:
  - `i_capture` passes through a 2-flop synchronizer plus a rising-edge detector.
  - On a detected edge, CAPTURE ← COUNT and CAPT ← 1.
  - Latency from `i_capture` rising to CAPTURE update is 3 edges.
  - CAPT is OR-ed into `o_irq` when IE=1.
  - A simultaneous clear and capture edge: set wins.
- Undefined: no synchronizer and no CAPTURE flops. Address 5 and STATUS.bit1 read 0. `i_capture` is unused.

## Structure
- Shared package `timer_pkg` holds:
  - Register address constants `TIMER_ADR_CTRL`..`TIMER_ADR_CAPTURE`.
  - CTRL bit indices EN/ONESHOT/IE and STATUS bit indices MATCH/CAPT.
- One sub-module, `timer_prescaler`: enable in, PRESCALE in, synchronous clear in, tick out.
- Counter, flags and bus decode live in the top module.

## Test plan
- Reset: hold `i_rst_n`=0 for 2 cycles, then read addresses 0–5 → all 0 and `o_irq`=0. Read address 6 → 0.
- Auto-reload: PRESCALE=1, RELOAD=3, COUNT=3, CTRL=0x5 → MATCH at 8-cycle intervals and `o_irq` high 1 cycle after the first match. Writing STATUS=1 drops `o_irq` on the next cycle, and it reasserts 8 cycles after the previous match.
- One-shot: PRESCALE=0, RELOAD=2, COUNT=2, CTRL=0x7 → single match 3 ticks after enable, CTRL reads 0x6, COUNT holds 2, no further matches.
- Collisions: STATUS=1 write in the exact match cycle → MATCH stays 1. COUNT=5 write in a tick cycle → COUNT reads 5, not 4.
- Reset mid-operation: with the counter running at COUNT=0x10, assert `i_rst_n`=0 for 1 cycle together with a CTRL write → all registers read 0 afterwards.
- Capture (`TIMER_CAPTURE_EN`): `i_capture` rising while COUNT=7 held (EN=0) → CAPTURE=7 and CAPT=1 after 3 edges, `o_irq`=1 with IE set. Without the macro the same stimulus reads CAPTURE=0 and CAPT=0.
